// File: rtl/retry_inorder_end.sv
// ---------------------------------------------------------------------------
// retry_inorder_end
// Consumer-side end of the retry loop. Faulty results are bounced back to the
// retry issuer as a failed ID; correct results are parked in an ID-indexed
// reorder buffer and released downstream strictly in ID order.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   data_i/id_i/faulty_i     result from the DMR checker, its ID, fault flag
//   valid_i/ready_o          upstream handshake
//   data_o/valid_o/ready_i   in-order downstream handshake (registered)
//   failed_id_o/_valid_o     retry request towards the issuer
//   failed_ready_i           issuer accepts the retry request
//   duplicate_o              1-cycle pulse: correct result hit an occupied slot
//   pending_o                number of occupied buffer slots
// ---------------------------------------------------------------------------
module retry_inorder_end #(
    parameter type         DataType = logic,
    parameter int unsigned ID_SIZE  = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  DataType            data_i,
    input  logic [ID_SIZE-1:0] id_i,
    input  logic               faulty_i,
    input  logic               valid_i,
    output logic               ready_o,
    output DataType            data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [ID_SIZE-1:0] failed_id_o,
    output logic               failed_valid_o,
    input  logic               failed_ready_i,
    output logic               duplicate_o,
    output logic [ID_SIZE:0]   pending_o
);
    localparam int unsigned DEPTH = 2 ** ID_SIZE;

    DataType            r_mem [DEPTH];
    logic [DEPTH-1:0]   r_occ;
    logic [ID_SIZE-1:0] r_next_id;
    logic [ID_SIZE:0]   r_cnt;
    logic               r_dup;

    logic               w_correct;
    logic               w_slot_busy;
    logic               w_wr;
    logic               w_dup;
    logic               w_rel;
    logic [DEPTH-1:0]   w_occ_nxt;

    assign w_correct   = valid_i & ~faulty_i;
    assign w_slot_busy = r_occ[id_i];
    // Correct results are always accepted; an occupied slot (including the
    // one being released this cycle) makes the incoming result a duplicate.
    assign w_wr        = w_correct & ~w_slot_busy;
    assign w_dup       = w_correct & w_slot_busy;
    assign w_rel       = r_occ[r_next_id] & ready_i;

    // Faulty results can only be consumed when the issuer takes the retry.
    assign ready_o        = faulty_i ? failed_ready_i : 1'b1;
    assign failed_valid_o = valid_i & faulty_i;
    assign failed_id_o    = id_i;

    // Output comes from state only, so there is no input-to-output bypass.
    assign valid_o     = r_occ[r_next_id];
    assign data_o      = r_mem[r_next_id];
    assign duplicate_o = r_dup;
    assign pending_o   = r_cnt;

    // A write targets a free slot and a release targets an occupied one, so
    // the two never collide on the same bit.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_rel) w_occ_nxt[r_next_id] = 1'b0;
        if (w_wr)  w_occ_nxt[id_i]      = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ     <= '0;
            r_next_id <= '0;
            r_cnt     <= '0;
            r_dup     <= 1'b0;
        end else begin
            r_occ <= w_occ_nxt;
            r_dup <= w_dup;
            if (w_rel) r_next_id <= r_next_id + 1'b1;
            unique case ({w_wr, w_rel})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy bits qualify it.
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[id_i] <= data_i;
    end

endmodule
